// File: rtl/id_pkg.sv
// Shared definitions for the decode-stage register read slice.
// Optional feature macro used by id_regfile_stage: ID_STALL_REFRESH_EN.
package id_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int RS1_LSB      = 15;
  localparam int RS2_LSB      = 20;
  localparam int RD_LSB       = 7;
  localparam int REG_IDX_W    = 5;

  typedef struct packed {
    logic                    valid;
    logic [REG_IDX_W-1:0]    rd;
    logic [XLEN_DEFAULT-1:0] value;
  } wb_port_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/id_regfile.sv
// Multi-port writeback register file with two async read ports and same-cycle write bypass.
// x0 is hardwired to zero; when several ports target one register the highest index wins.
module id_regfile
  import id_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_WB   = 2,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_WB-1:0]        i_wb_valid,
  input  logic [NUM_WB*ADDR_W-1:0] i_wb_rd,
  input  logic [NUM_WB*XLEN-1:0]   i_wb_value,
  input  logic [ADDR_W-1:0]        i_rs1_idx,
  input  logic [ADDR_W-1:0]        i_rs2_idx,
  output logic [XLEN-1:0]          o_rs1_value,
  output logic [XLEN-1:0]          o_rs2_value
);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [XLEN:0]   w_win  [NUM_REGS];
  logic [XLEN:0]   w_rs1Win;
  logic [XLEN:0]   w_rs2Win;

  // Returns {hit, value}; later ports overwrite earlier ones so the highest index wins.
  function automatic logic [XLEN:0] resolveWrite(
    input logic [ADDR_W-1:0]        idx,
    input logic [NUM_WB-1:0]        wbValid,
    input logic [NUM_WB*ADDR_W-1:0] wbRd,
    input logic [NUM_WB*XLEN-1:0]   wbValue
  );
    logic [XLEN:0] win;
    win = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wbValid[k] && (wbRd[k*ADDR_W +: ADDR_W] == idx) && (idx != '0)) begin
        win = {1'b1, wbValue[k*XLEN +: XLEN]};
      end
    end
    return win;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_win[i] = resolveWrite(ADDR_W'(i), i_wb_valid, i_wb_rd, i_wb_value);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_win[i][XLEN]) begin
          r_regs[i] <= w_win[i][XLEN-1:0];
        end
      end
    end
  end

  assign w_rs1Win = resolveWrite(i_rs1_idx, i_wb_valid, i_wb_rd, i_wb_value);
  assign w_rs2Win = resolveWrite(i_rs2_idx, i_wb_valid, i_wb_rd, i_wb_value);

  assign o_rs1_value = (i_rs1_idx == '0) ? '0 :
                       w_rs1Win[XLEN] ? w_rs1Win[XLEN-1:0] : r_regs[i_rs1_idx];
  assign o_rs2_value = (i_rs2_idx == '0) ? '0 :
                       w_rs2Win[XLEN] ? w_rs2Win[XLEN-1:0] : r_regs[i_rs2_idx];

endmodule

// File: rtl/id_regfile_stage.sv
// Decode stage: register read into a valid/ready output register with stall and flush.
// Define ID_STALL_REFRESH_EN to let writebacks refresh the operands of a stalled instruction.
module id_regfile_stage
  import id_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_WB   = 2,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_inst_valid,
  output logic                     o_inst_ready,
  input  logic [31:0]              i_inst,
  input  logic [XLEN-1:0]          i_inst_addr,
  input  logic                     i_flush,
  input  logic [NUM_WB-1:0]        i_wb_valid,
  input  logic [NUM_WB*ADDR_W-1:0] i_wb_rd,
  input  logic [NUM_WB*XLEN-1:0]   i_wb_value,
  output logic                     o_inst_valid,
  input  logic                     i_out_ready,
  output logic [31:0]              o_inst,
  output logic [XLEN-1:0]          o_inst_addr,
  output logic [XLEN-1:0]          o_rs1_value,
  output logic [XLEN-1:0]          o_rs2_value
);

  out_state_t        r_state;
  logic [31:0]       r_inst;
  logic [XLEN-1:0]   r_instAddr;
  logic [XLEN-1:0]   r_rs1Value;
  logic [XLEN-1:0]   r_rs2Value;
  logic              w_accept;
  logic [ADDR_W-1:0] w_rs1Idx;
  logic [ADDR_W-1:0] w_rs2Idx;
  logic [XLEN-1:0]   w_rs1Read;
  logic [XLEN-1:0]   w_rs2Read;

  assign o_inst_valid = (r_state == ST_FULL);
  assign o_inst_ready = !o_inst_valid || i_out_ready;
  assign w_accept     = i_inst_valid && o_inst_ready;

`ifdef ID_STALL_REFRESH_EN
  logic w_stall;
  assign w_stall = (r_state == ST_FULL) && !i_out_ready;
  // A stall blocks accept, so the read ports are free to re-read the held instruction's sources.
  assign w_rs1Idx = w_stall ? ADDR_W'(r_inst[RS1_LSB +: REG_IDX_W]) : ADDR_W'(i_inst[RS1_LSB +: REG_IDX_W]);
  assign w_rs2Idx = w_stall ? ADDR_W'(r_inst[RS2_LSB +: REG_IDX_W]) : ADDR_W'(i_inst[RS2_LSB +: REG_IDX_W]);
`else
  assign w_rs1Idx = ADDR_W'(i_inst[RS1_LSB +: REG_IDX_W]);
  assign w_rs2Idx = ADDR_W'(i_inst[RS2_LSB +: REG_IDX_W]);
`endif

  id_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .NUM_WB   (NUM_WB)
  ) u_regfile (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wb_valid  (i_wb_valid),
    .i_wb_rd     (i_wb_rd),
    .i_wb_value  (i_wb_value),
    .i_rs1_idx   (w_rs1Idx),
    .i_rs2_idx   (w_rs2Idx),
    .o_rs1_value (w_rs1Read),
    .o_rs2_value (w_rs2Read)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_EMPTY;
      r_inst     <= '0;
      r_instAddr <= '0;
      r_rs1Value <= '0;
      r_rs2Value <= '0;
    end else if (i_flush) begin
      r_state <= ST_EMPTY;
    end else if (w_accept) begin
      r_state    <= ST_FULL;
      r_inst     <= i_inst;
      r_instAddr <= i_inst_addr;
      r_rs1Value <= w_rs1Read;
      r_rs2Value <= w_rs2Read;
    end else if ((r_state == ST_FULL) && i_out_ready) begin
      r_state <= ST_EMPTY;
`ifdef ID_STALL_REFRESH_EN
    end else if (w_stall) begin
      // Without a hit the re-read returns the value already held, so reloading every stall cycle is safe.
      r_rs1Value <= w_rs1Read;
      r_rs2Value <= w_rs2Read;
`endif
    end
  end

  assign o_inst      = r_inst;
  assign o_inst_addr = r_instAddr;
  assign o_rs1_value = r_rs1Value;
  assign o_rs2_value = r_rs2Value;

endmodule
